ysyx_24090003_lsu: RTL

Load/store unit for the single-issue ysyx_24090003 core. It takes one memory request from the execute stage, drives one transaction on the core's data-memory bus, and returns aligned, sign- or zero-extended load data to write-back, where that data becomes the memory-read input. Requests and responses use valid/ready handshakes, so the unit tolerates memory latency and back-pressure from write-back.

---
 rtl/ysyx_24090003_lsu_pkg.sv | 40 ++++
 rtl/ysyx_24090003_lsu_ext.sv | 30 +++
 rtl/ysyx_24090003_lsu.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ysyx_24090003_lsu_pkg.sv
// Shared constants for the ysyx_24090003 LSU: funct3 codes, FSM states,
// base byte-strobe patterns and request legality helpers.
package ysyx_24090003_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] WSTRB_B = 4'b0001;
  localparam logic [3:0] WSTRB_H = 4'b0011;
  localparam logic [3:0] WSTRB_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  function automatic logic f3_legal(input logic wen, input logic [2:0] f3);
    if (wen) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // funct3[1:0] encodes access size for every legal load and store
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_24090003_lsu_ext.sv
// Load-data extractor: picks the byte/halfword at the request offset and
// sign- or zero-extends it according to funct3.
module ysyx_24090003_lsu_ext
  import ysyx_24090003_lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] shifted;

  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   data_o = rdata_i;
      F3_LBU:  data_o = {24'h000000, shifted[7:0]};
      F3_LHU:  data_o = {16'h0000, shifted[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_24090003_lsu.sv
// Load/store unit: accepts one request, runs one data-bus transaction and
// returns extended load data (or an error) to write-back.
module ysyx_24090003_lsu
  import ysyx_24090003_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wen,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic [2:0]        i_req_funct3,
  output logic              o_bus_valid,
  input  logic              i_bus_ready,
  output logic              o_bus_wen,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  output logic [3:0]        o_bus_wstrb,
  input  logic              i_bus_rvalid,
  output logic              o_bus_rready,
  input  logic [DATA_W-1:0] i_bus_rdata,
  input  logic              i_bus_err,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err
);

  lsu_state_e        state_q, state_d;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [2:0]        funct3_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              accept;
  logic              resp_hs;
  logic              req_bad;
  logic [DATA_W-1:0] lane_wdata;
  logic [3:0]        lane_wstrb;
  logic [DATA_W-1:0] ext_data;

  assign accept  = (state_q == ST_IDLE) && i_req_valid;
  assign resp_hs = (state_q == ST_RESP) && i_bus_rvalid;
  assign req_bad = !f3_legal(i_req_wen, i_req_funct3) ||
                   misaligned(i_req_funct3, i_req_addr[1:0]);

  // Lanes are computed at accept time so the bus side is a plain register.
  always_comb begin
    lane_wdata = '0;
    lane_wstrb = '0;
    if (i_req_wen) begin
      case (i_req_funct3)
        F3_SB: begin
          lane_wdata = {4{i_req_wdata[7:0]}};
          lane_wstrb = WSTRB_B << i_req_addr[1:0];
        end
        F3_SH: begin
          lane_wdata = {2{i_req_wdata[15:0]}};
          lane_wstrb = WSTRB_H << i_req_addr[1:0];
        end
        F3_SW: begin
          lane_wdata = i_req_wdata;
          lane_wstrb = WSTRB_W;
        end
        default: begin
          lane_wdata = '0;
          lane_wstrb = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_req_valid)  state_d = req_bad ? ST_DONE : ST_REQ;
      ST_REQ:  if (i_bus_ready)  state_d = ST_RESP;
      ST_RESP: if (i_bus_rvalid) state_d = ST_DONE;
      ST_DONE: if (i_rsp_ready)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready  = 1'b0;
    o_bus_valid  = 1'b0;
    o_bus_rready = 1'b0;
    o_rsp_valid  = 1'b0;
    case (state_q)
      ST_IDLE: o_req_ready  = 1'b1;
      ST_REQ:  o_bus_valid  = 1'b1;
      ST_RESP: o_bus_rready = 1'b1;
      ST_DONE: o_rsp_valid  = 1'b1;
      default: o_req_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      funct3_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      wen_q    <= i_req_wen;
      addr_q   <= i_req_addr;
      wdata_q  <= lane_wdata;
      wstrb_q  <= lane_wstrb;
      funct3_q <= i_req_funct3;
      rdata_q  <= '0;
      err_q    <= req_bad;
    end else if (resp_hs) begin
      rdata_q  <= (i_bus_err || wen_q) ? '0 : ext_data;
      err_q    <= i_bus_err;
    end
  end

  ysyx_24090003_lsu_ext #(
    .DATA_W (DATA_W)
  ) u_ext (
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_q[1:0]),
    .rdata_i   (i_bus_rdata),
    .data_o    (ext_data)
  );

  assign o_bus_wen   = wen_q;
  assign o_bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign o_bus_wdata = wdata_q;
  assign o_bus_wstrb = wstrb_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;

endmodule
